seq_alu_unit: RTL and testbench
===============================

# seq_alu_unit

Registered, multi-cycle ALU for the RV32I datapath. It merges operation decoding (ALUOp, funct3, funct7, opcode bit 5) with execution and is parametrised in data width and shifter step size. Single-cycle logic ops sit alongside an iterative shifter and an optional iterative multiplier. It sits between register read and writeback and uses a valid/ready handshake on both sides, so the control FSM can stall on long operations.

## Interface
Parameters:
- XLEN, 32, datapath width; must be a power of two, ≥ 8.
- SHIFT_STEP, 1, bits shifted per cycle by the iterative shifter; power of two, 1..XLEN.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept an operation
- ALUOp  in  2  00 add, 01 sub, 10 decode funct fields, 11 illegal
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- funct7b0  in  1  instruction bit 25 (M-extension select)
- opb5  in  1  opcode bit 5 (1 = R-type)
- a  in  XLEN  operand A
- b  in  XLEN  operand B / immediate
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  result == 0
- illegal  out  1  decoded operation unsupported; qualifies out_valid
- busy  out  1  state is SHIFT or MUL

## Operation
- FSM states: IDLE, SHIFT, MUL, DONE.
- IDLE: in_ready=1. On in_valid, capture a, b, and the decoded op.
  - Logic/arith/compare ops and illegal ops go to DONE.
  - Shifts go to SHIFT, or to DONE directly if shamt=0.
  - MUL goes to MUL.
- Decode when ALUOp=10, by funct3:
  - 000: sub if funct7b5 & opb5, else add.
  - 001: sll. 010: slt (signed). 011: sltu. 100: xor.
  - 101: sra if funct7b5, else srl.
  - 110: or. 111: and.
- ALUOp=00 is add and ALUOp=01 is sub, regardless of funct fields. ALUOp=11 is illegal.
- Arithmetic rules:
  - add/sub wrap mod 2^XLEN.
  - slt/sltu return 1 or 0, zero-extended.
  - shamt = b[log2(XLEN)-1:0]; upper bits of b are ignored.
  - sra fills with a[XLEN-1].
- SHIFT: each cycle shifts by min(SHIFT_STEP, remaining); goes to DONE when remaining reaches 0.
- MUL: low XLEN bits of a*b via shift-add, one multiplier bit per cycle, XLEN cycles, then DONE.
- opb5 & funct7b0 with ALUOp=10:
  - funct3=000 is MUL (macro-dependent, see Configuration).
  - Any other funct3 is illegal.
- Illegal ops: result=0, illegal=1, zero=1.
- DONE: out_valid=1 and outputs held stable until out_ready, then IDLE. No new operation is accepted in DONE.
- result, zero and illegal are registered. They change only on the cycle DONE is entered.

## Timing
- Reset (asynchronous, any state, including mid-SHIFT or mid-MUL):
  - State goes to IDLE. The in-flight operation is discarded and never produces out_valid.
  - in_ready=1; out_valid=0, result=0, zero=0, illegal=0, busy=0.
- Latency from the accept edge to out_valid:
  - 1 cycle for single-cycle ops and for shifts with shamt=0.
  - 1 + ceil(shamt/SHIFT_STEP) cycles for shifts.
  - XLEN+1 cycles for MUL.
- out_valid & out_ready → IDLE at the next edge; the earliest next accept is one cycle after that.
- Throughput: one operation every 2 cycles at best.
- Inputs are sampled only on the accept edge; later changes to a, b or the funct fields have no effect.
- in_valid while busy or in DONE is ignored, not queued.

## Configuration
- SEQ_ALU_MUL_EN defined: the MUL state and shift-add datapath are compiled in; MUL executes as described above.
- SEQ_ALU_MUL_EN undefined: no MUL state or multiplier datapath. The MUL encoding decodes as illegal with 1-cycle latency.

## Test plan
- XLEN=32: ALUOp=10, funct3=000, opb5=1, funct7b5=1, a=5, b=7 → after 1 cycle, result=0xFFFFFFFE, zero=0, illegal=0. Same inputs with opb5=0 → result=12.
- funct3=101, funct7b5=1, a=0x80000000, b=0x24 (shamt=4), SHIFT_STEP=1 → out_valid at cycle 5, result=0xF8000000. With SHIFT_STEP=4 → out_valid at cycle 2.
- funct3=010 with a=0xFFFFFFFF, b=1 → result=1. Same operands with funct3=011 → result=0.
- MUL (macro on), a=0xFFFFFFFF, b=3 → out_valid at cycle 33, result=0xFFFFFFFD. Macro off → cycle 1, illegal=1, result=0, zero=1.
- Hold out_ready=0 for 5 cycles in DONE → result and out_valid stable; in_valid pulses ignored. On out_ready=1 → in_ready=1 on the next cycle.
- Assert rst_n=0 mid-SHIFT with shamt=31 → outputs and state cleared immediately. After release, a new add of 1+1 → result=2 with latency 1.

Source files
------------

// File: rtl/seq_alu_unit_if.sv
// ----------------------------------------------------------------------------
// seq_alu_unit_if
// Bundle of the request/response signals for seq_alu_unit.
//
//   in_valid / in_ready    request handshake (requester -> ALU)
//   ALUOp, funct3,         decode fields of the instruction
//   funct7b5, funct7b0,
//   opb5
//   a, b                   operands (b doubles as immediate / shift amount)
//   out_valid / out_ready  response handshake (ALU -> consumer)
//   result, zero, illegal  registered response
//   busy                   ALU is iterating (shift or multiply)
//
// Modports:
//   master : requester/consumer side (drives request fields and out_ready)
//   slave  : the ALU itself
// ----------------------------------------------------------------------------
interface seq_alu_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            funct7b0;
  logic            opb5;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic            busy;

  modport master (
    output in_valid, ALUOp, funct3, funct7b5, funct7b0, opb5, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, busy
  );

  modport slave (
    input  in_valid, ALUOp, funct3, funct7b5, funct7b0, opb5, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal, busy
  );
endinterface

// File: rtl/seq_alu_unit.sv
// ----------------------------------------------------------------------------
// seq_alu_unit
// Registered multi-cycle RV32I ALU with built-in operation decode.
// Single-cycle ops (add/sub/slt/sltu/xor/or/and) complete in one cycle,
// shifts iterate SHIFT_STEP bits per cycle, and the optional multiplier
// iterates one multiplier bit per cycle (shift-add).
//
// Parameters:
//   XLEN        datapath width, power of two, >= 8
//   SHIFT_STEP  bits shifted per cycle, power of two, 1..XLEN
//
// Ports:
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    seq_alu_unit_if.slave: request fields + in handshake,
//          result/zero/illegal + out handshake, busy
//
// Optional feature macro:
//   SEQ_ALU_MUL_EN  when defined, the MUL state and shift-add multiplier are
//                   built; otherwise the MUL encoding decodes as illegal.
// ----------------------------------------------------------------------------
module seq_alu_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_alu_unit_if.slave bus
);

  localparam int SHW = $clog2(XLEN);
  // Step kept one bit wider than shamt so SHIFT_STEP == XLEN is representable.
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
  } op_e;

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd3
  } state_e;
`endif

  state_e          state_reg, state_next;
  op_e             op_reg, op_next;
  logic [XLEN-1:0] work_reg, work_next;
  logic [SHW-1:0]  rem_reg, rem_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            zero_reg, zero_next;
  logic            illegal_reg, illegal_next;

`ifdef SEQ_ALU_MUL_EN
  logic [XLEN-1:0] mcand_reg, mcand_next;
  logic [XLEN-1:0] mplier_reg, mplier_next;
  logic [XLEN-1:0] acc_reg, acc_next;
  logic [SHW-1:0]  cnt_reg, cnt_next;
  logic [XLEN-1:0] mul_sum;
`endif

  // --------------------------------------------------------------------------
  // Decode of the request fields (only meaningful in IDLE)
  // --------------------------------------------------------------------------
  op_e             dec_op;
  logic            dec_is_shift;
  logic [SHW-1:0]  shamt_in;
  logic [XLEN-1:0] alu_res;

  always_comb begin
    dec_op = OP_ILL;
    case (bus.ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        if (bus.opb5 && bus.funct7b0) begin
          // M-extension space: only MUL exists, and only when built in.
`ifdef SEQ_ALU_MUL_EN
          dec_op = (bus.funct3 == 3'b000) ? OP_MUL : OP_ILL;
`else
          dec_op = OP_ILL;
`endif
        end else begin
          case (bus.funct3)
            3'b000:  dec_op = (bus.funct7b5 && bus.opb5) ? OP_SUB : OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = bus.funct7b5 ? OP_SRA : OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end
      end
      default: dec_op = OP_ILL;
    endcase
  end

  assign dec_is_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);
  assign shamt_in     = bus.b[SHW-1:0];

  // Single-cycle result. Shifts pass a through, which is the answer when
  // shamt is zero; illegal ops yield zero.
  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_SLL, OP_SRL, OP_SRA: alu_res = bus.a;
      default: alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Iterative shifter step: min(SHIFT_STEP, remaining) bits per cycle
  // --------------------------------------------------------------------------
  logic [SHW:0]    rem_ext;
  logic [SHW:0]    step;
  logic [SHW-1:0]  rem_after;
  logic [XLEN-1:0] shifted;

  assign rem_ext   = {1'b0, rem_reg};
  assign step      = (rem_ext < STEP) ? rem_ext : STEP;
  // step never exceeds rem_reg, so the truncation below is lossless.
  assign rem_after = rem_reg - step[SHW-1:0];

  always_comb begin
    case (op_reg)
      OP_SLL:  shifted = work_reg << step;
      OP_SRA:  shifted = $signed(work_reg) >>> step;
      default: shifted = work_reg >> step;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  assign mul_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif

  // --------------------------------------------------------------------------
  // Control FSM: next state and datapath updates
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    work_next    = work_reg;
    rem_next     = rem_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    illegal_next = illegal_reg;
`ifdef SEQ_ALU_MUL_EN
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          op_next   = dec_op;
          work_next = bus.a;
          rem_next  = shamt_in;
          if (dec_is_shift && (shamt_in != '0)) begin
            state_next = SHIFT;
          end
`ifdef SEQ_ALU_MUL_EN
          else if (dec_op == OP_MUL) begin
            acc_next    = '0;
            mcand_next  = bus.a;
            mplier_next = bus.b;
            cnt_next    = SHW'(XLEN-1);
            state_next  = MUL;
          end
`endif
          else begin
            state_next   = DONE;
            result_next  = alu_res;
            zero_next    = (alu_res == '0);
            illegal_next = (dec_op == OP_ILL);
          end
        end
      end

      SHIFT: begin
        work_next = shifted;
        rem_next  = rem_after;
        // The final step's value is written straight into result so the
        // response registers only ever change on DONE entry.
        if (rem_after == '0) begin
          state_next   = DONE;
          result_next  = shifted;
          zero_next    = (shifted == '0);
          illegal_next = 1'b0;
        end
      end

`ifdef SEQ_ALU_MUL_EN
      MUL: begin
        acc_next    = mul_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          state_next   = DONE;
          result_next  = mul_sum;
          zero_next    = (mul_sum == '0);
          illegal_next = 1'b0;
        end
      end
`endif

      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      op_reg      <= OP_ADD;
      work_reg    <= '0;
      rem_reg     <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      work_reg    <= work_next;
      rem_reg     <= rem_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      illegal_reg <= illegal_next;
`ifdef SEQ_ALU_MUL_EN
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
`ifdef SEQ_ALU_MUL_EN
  assign bus.busy      = (state_reg == SHIFT) || (state_reg == MUL);
`else
  assign bus.busy      = (state_reg == SHIFT);
`endif
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.illegal   = illegal_reg;

endmodule

// File: tb/tb_seq_alu_unit.sv
// ----------------------------------------------------------------------------
// tb_seq_alu_unit
// Directed bench for seq_alu_unit. Two instances share one stimulus stream:
// dut1 with SHIFT_STEP=1 and dut2 with SHIFT_STEP=4, so shift latency can be
// checked for both step sizes. MUL expectations follow SEQ_ALU_MUL_EN.
// ----------------------------------------------------------------------------
module tb_seq_alu_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_alu_unit_if #(.XLEN(32)) ifa ();
  seq_alu_unit_if #(.XLEN(32)) ifb ();

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.ALUOp     = ifa.ALUOp;
  assign ifb.funct3    = ifa.funct3;
  assign ifb.funct7b5  = ifa.funct7b5;
  assign ifb.funct7b0  = ifa.funct7b0;
  assign ifb.opb5      = ifa.opb5;
  assign ifb.a         = ifa.a;
  assign ifb.b         = ifa.b;
  assign ifb.out_ready = ifa.out_ready;

  seq_alu_unit #(.XLEN(32), .SHIFT_STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifa));
  seq_alu_unit #(.XLEN(32), .SHIFT_STEP(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int tests = 0;
  int fails = 0;
  int lat1, lat2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs after the accept edge, then count
  // cycles (accept edge = 1) until each instance raises out_valid.
  task automatic do_op(input string name, input logic [1:0] op, input logic [2:0] f3,
                       input logic f7b5, input logic f7b0, input logic ob5,
                       input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    ifa.ALUOp = op; ifa.funct3 = f3; ifa.funct7b5 = f7b5; ifa.funct7b0 = f7b0;
    ifa.opb5 = ob5; ifa.a = av; ifa.b = bv; ifa.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
    ifa.a = ~av; ifa.b = ~bv; ifa.funct3 = ~f3; ifa.ALUOp = ~op;
    lat1 = 0; lat2 = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (lat1 == 0 && ifa.out_valid) lat1 = n;
      if (lat2 == 0 && ifb.out_valid) lat2 = n;
      if (lat1 != 0 && lat2 != 0) break;
    end
    $display("[TB] %s a=0x%08h b=0x%08h -> result=0x%08h zero=%0b illegal=%0b lat=%0d/%0d",
             name, av, bv, ifa.result, ifa.zero, ifa.illegal, lat1, lat2);
  endtask

  task automatic retire(input string name);
    @(negedge clk);
    ifa.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifa.out_ready = 1'b0;
    check({name, ".in_ready1"}, {31'b0, ifa.in_ready}, 32'd1);
    check({name, ".in_ready2"}, {31'b0, ifb.in_ready}, 32'd1);
  endtask

  task automatic expect_res(input string name, input logic [31:0] r, input logic z,
                            input logic il, input int l1, input int l2);
    check({name, ".result1"}, ifa.result, r);
    check({name, ".result2"}, ifb.result, r);
    check({name, ".zero"}, {31'b0, ifa.zero}, {31'b0, z});
    check({name, ".illegal"}, {31'b0, ifa.illegal}, {31'b0, il});
    check({name, ".lat1"}, lat1, l1);
    check({name, ".lat2"}, lat2, l2);
    retire(name);
  endtask

  initial begin
    logic seen_valid;
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.ALUOp = 2'b00; ifa.funct3 = 3'b000; ifa.funct7b5 = 1'b0;
    ifa.funct7b0 = 1'b0; ifa.opb5 = 1'b0; ifa.a = '0; ifa.b = '0; ifa.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", {31'b0, ifa.in_ready}, 32'd1);
    check("rst.out_valid", {31'b0, ifa.out_valid}, 32'd0);
    check("rst.result", ifa.result, 32'd0);
    check("rst.zero", {31'b0, ifa.zero}, 32'd0);
    check("rst.illegal", {31'b0, ifa.illegal}, 32'd0);
    check("rst.busy", {31'b0, ifa.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("sub", 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7);
    expect_res("sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 1);
    do_op("addi", 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7);
    expect_res("addi", 32'd12, 1'b0, 1'b0, 1, 1);
    do_op("sra4", 2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h24);
    expect_res("sra4", 32'hF800_0000, 1'b0, 1'b0, 5, 2);
    do_op("srl8", 2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'hF000_0000, 32'd8);
    expect_res("srl8", 32'h00F0_0000, 1'b0, 1'b0, 9, 3);
    do_op("sll31", 2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'd1, 32'h1F);
    expect_res("sll31", 32'h8000_0000, 1'b0, 1'b0, 32, 9);
    do_op("sll0", 2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h20);
    expect_res("sll0", 32'h1234, 1'b0, 1'b0, 1, 1);
    do_op("slt", 2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
    expect_res("slt", 32'd1, 1'b0, 1'b0, 1, 1);
    do_op("sltu", 2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
    expect_res("sltu", 32'd0, 1'b1, 1'b0, 1, 1);
    do_op("xor", 2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00);
    expect_res("xor", 32'h0FF0_0FF0, 1'b0, 1'b0, 1, 1);
    do_op("or", 2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00);
    expect_res("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1, 1);
    do_op("and", 2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00);
    expect_res("and", 32'hF000_F000, 1'b0, 1'b0, 1, 1);
    do_op("aluop00", 2'b00, 3'b111, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
    expect_res("aluop00", 32'd0, 1'b1, 1'b0, 1, 1);
    do_op("aluop01", 2'b01, 3'b110, 1'b0, 1'b0, 1'b1, 32'd10, 32'd3);
    expect_res("aluop01", 32'd7, 1'b0, 1'b0, 1, 1);
    do_op("aluop11", 2'b11, 3'b000, 1'b0, 1'b0, 1'b1, 32'd10, 32'd3);
    expect_res("aluop11", 32'd0, 1'b1, 1'b1, 1, 1);
    do_op("mul", 2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd3);
`ifdef SEQ_ALU_MUL_EN
    expect_res("mul", 32'hFFFF_FFFD, 1'b0, 1'b0, 33, 33);
`else
    expect_res("mul", 32'd0, 1'b1, 1'b1, 1, 1);
`endif
    do_op("mext001", 2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'd6, 32'd2);
    expect_res("mext001", 32'd0, 1'b1, 1'b1, 1, 1);
    do_op("itype_b25", 2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 32'd2, 32'd3);
    expect_res("itype_b25", 32'd5, 1'b0, 1'b0, 1, 1);

    // Hold DONE with out_ready low; new requests must be ignored.
    do_op("hold_add", 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
    check("hold.lat", lat1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ifa.in_valid = 1'b1; ifa.ALUOp = 2'b00; ifa.a = 32'd100 + i; ifa.b = 32'd1;
      @(posedge clk);
      #1;
      check("hold.out_valid", {31'b0, ifa.out_valid}, 32'd1);
      check("hold.result", ifa.result, 32'd7);
      check("hold.in_ready", {31'b0, ifa.in_ready}, 32'd0);
    end
    ifa.in_valid = 1'b0;
    retire("hold");
    check("hold.out_valid_after", {31'b0, ifa.out_valid}, 32'd0);
    $display("[TB] hold_release result=0x%08h in_ready=%0b", ifa.result, ifa.in_ready);

    // Asynchronous reset in the middle of a long shift.
    @(negedge clk);
    ifa.ALUOp = 2'b10; ifa.funct3 = 3'b001; ifa.funct7b5 = 1'b0; ifa.funct7b0 = 1'b0;
    ifa.opb5 = 1'b1; ifa.a = 32'd1; ifa.b = 32'd31; ifa.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst.busy_before", {31'b0, ifa.busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.busy", {31'b0, ifa.busy}, 32'd0);
    check("midrst.in_ready", {31'b0, ifa.in_ready}, 32'd1);
    check("midrst.out_valid", {31'b0, ifa.out_valid}, 32'd0);
    check("midrst.result", ifa.result, 32'd0);
    check("midrst.busy2", {31'b0, ifb.busy}, 32'd0);
    $display("[TB] midshift_reset busy=%0b in_ready=%0b result=0x%08h", ifa.busy, ifa.in_ready, ifa.result);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifa.out_valid || ifb.out_valid) seen_valid = 1'b1;
    end
    check("midrst.no_out_valid", {31'b0, seen_valid}, 32'd0);
    do_op("post_rst_add", 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
    expect_res("post_rst_add", 32'd2, 1'b0, 1'b0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
